guess_round_ctrl: RTL and testbench
===================================

// Module: guess_round_ctrl
// PURPOSE
//  Round sequencer for the 6-bit number-guessing game. Owns the secret-number LFSR, attempt
//  counter, per-bit match datapath and win/lose/score bookkeeping. Sits between the pin-level
//  input decode (which supplies guess + a one-cycle submit strobe) and the io_out driver.
// PARAMETERS
//  MAX_TRIES    3      guesses allowed per round (1..7)
//  HOLD_CYCLES  8      cycles the final result is held in SHOW before the round ends (>=1)
//  LFSR_SEED    6'h2D  LFSR value loaded on reset; 0 is illegal and is replaced by 6'h01
//  SCORE_W      4      width of the saturating win counter
// PORTS
//  clk          in   1        single clock; all state updates on posedge
//  rst          in   1        synchronous reset, active-high
//  start        in   1        level; request a new round (sampled in IDLE and at end of SHOW)
//  guess        in   6        guessed value, sampled only with guess_valid
//  guess_valid  in   1        one-cycle submit strobe
//  guess_ready  out  1        1 only in PLAY; guess_valid is ignored when 0
//  result       out  6        per-bit match mask of the last accepted guess (1 = bit correct)
//  win          out  1        last round ended with a correct guess
//  lose         out  1        last round ended with tries exhausted
//  tries_left   out  3        guesses remaining in current round
//  score        out  SCORE_W  total wins since reset, saturating
//  state        out  2        IDLE=0 ARM=1 PLAY=2 SHOW=3 (debug/visibility)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, lfsr=LFSR_SEED, secret=0, result=0, win=0, lose=0,
//   tries_left=0, score=0, hold counter=0. Reset mid-round aborts the round, with no score change.
//  LFSR: 6-bit Fibonacci, x^6+x^5+1, next = {lfsr[4:0], lfsr[5]^lfsr[4]}. Advances every
//   non-reset cycle regardless of state; period 63 and never zero.
//  IDLE: guess_ready=0. start=1 -> ARM. Outputs keep their last-round values.
//  ARM (exactly 1 cycle): secret<=lfsr; tries_left<=MAX_TRIES; result,win,lose<=0 -> PLAY.
//  PLAY: guess_ready=1. Only when guess_valid=1 in that cycle, at the posedge:
//   result <= ~(guess ^ secret); tries_left <= tries_left-1;
//   guess==secret -> win<=1, score<=score+1 (holds at all-ones), -> SHOW;
//   else if tries_left==1 -> lose<=1 -> SHOW; else stay in PLAY.
//   Latency: result/win/lose/tries_left are visible the cycle after the accepting edge.
//   A correct guess on the last try is a win, never a lose. win and lose are never both 1.
//   start is ignored in PLAY. With no guess_valid, PLAY waits forever; there is no timeout.
//  SHOW: guess_ready=0. Hold counter counts HOLD_CYCLES cycles. On the final cycle:
//   start=1 -> ARM (back-to-back rounds), else -> IDLE. guess_valid is ignored.
//  Secret is internal and is never driven out. tries_left never underflows below 0.
// TESTING
//  1 rst; start=1 in first post-reset cycle -> ARM captures secret 6'h1B; guess 6'h1B valid
//    -> next cycle result=6'h3F, win=1, lose=0, score=1, tries_left=2, state=SHOW.
//  2 Same secret; guess 6'h00 -> result=6'h24, tries_left=2, state stays PLAY, win=lose=0.
//  3 Three wrong guesses (6'h00,6'h01,6'h02) -> after 3rd: lose=1, tries_left=0; SHOW for
//    8 cycles; start=0 -> IDLE; outputs held; later guess_valid does not change result.
//  4 guess_valid pulses in IDLE, ARM and SHOW -> no change to result/tries_left/score.
//  5 SCORE_W=2, four wins -> score 1,2,3,3 (saturates); start held high across SHOW -> ARM
//    directly with no IDLE cycle.
//  6 rst asserted mid-PLAY after one wrong guess -> next cycle state=IDLE, all outputs 0,
//    score=0; repeat scenario 1 timing -> secret again 6'h1B.

Source files
------------

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the 6-bit guessing game: secret LFSR, attempt counter,
// per-bit match result and win/lose/score bookkeeping.
module guess_round_ctrl #(
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter logic [5:0]  LFSR_SEED   = 6'h2D,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         guess,
    input  logic               guess_valid,
    output logic               guess_ready,
    output logic [5:0]         result,
    output logic               win,
    output logic               lose,
    output logic [2:0]         tries_left,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state
);

    // An all-zero seed would lock the LFSR, so it is swapped for a legal value.
    localparam logic [5:0]         SEED_SAFE  = (LFSR_SEED == 6'h00) ? 6'h01 : LFSR_SEED;
    localparam int unsigned        HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]         TRIES_INIT = 3'(MAX_TRIES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PLAY = 2'd2,
        ST_SHOW = 2'd3
    } state_t;

    function automatic logic [5:0] lfsr_next(input logic [5:0] cur);
        return {cur[4:0], cur[5] ^ cur[4]};
    endfunction

    state_t             state_r;
    logic [5:0]         lfsr_r;
    logic [5:0]         secret_r;
    logic [5:0]         result_r;
    logic               win_r;
    logic               lose_r;
    logic [2:0]         tries_r;
    logic [SCORE_W-1:0] score_r;
    logic [HOLD_W-1:0]  hold_r;
    logic               guess_ready_r;

    // Round sequencing, LFSR stepping and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            lfsr_r        <= SEED_SAFE;
            secret_r      <= 6'h00;
            result_r      <= 6'h00;
            win_r         <= 1'b0;
            lose_r        <= 1'b0;
            tries_r       <= 3'd0;
            score_r       <= {SCORE_W{1'b0}};
            hold_r        <= {HOLD_W{1'b0}};
            guess_ready_r <= 1'b0;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_ARM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    secret_r      <= lfsr_r;
                    tries_r       <= TRIES_INIT;
                    result_r      <= 6'h00;
                    win_r         <= 1'b0;
                    lose_r        <= 1'b0;
                    state_r       <= ST_PLAY;
                    guess_ready_r <= 1'b1;
                end
                ST_PLAY: begin
                    if (guess_valid) begin
                        result_r <= ~(guess ^ secret_r);
                        if (tries_r != 3'd0) begin
                            tries_r <= tries_r - 3'd1;
                        end else begin
                            tries_r <= 3'd0;
                        end
                        // A hit on the last try takes the win branch first.
                        if (guess == secret_r) begin
                            win_r         <= 1'b1;
                            score_r       <= (score_r == SCORE_MAX) ? score_r : score_r + SCORE_ONE;
                            hold_r        <= {HOLD_W{1'b0}};
                            guess_ready_r <= 1'b0;
                            state_r       <= ST_SHOW;
                        end else if (tries_r == 3'd1) begin
                            lose_r        <= 1'b1;
                            hold_r        <= {HOLD_W{1'b0}};
                            guess_ready_r <= 1'b0;
                            state_r       <= ST_SHOW;
                        end else begin
                            state_r <= ST_PLAY;
                        end
                    end else begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_SHOW: begin
                    if (hold_r == HOLD_LAST) begin
                        hold_r  <= {HOLD_W{1'b0}};
                        state_r <= start ? ST_ARM : ST_IDLE;
                    end else begin
                        hold_r  <= hold_r + HOLD_W'(1'b1);
                        state_r <= ST_SHOW;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    guess_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign guess_ready = guess_ready_r;
    assign result      = result_r;
    assign win         = win_r;
    assign lose        = lose_r;
    assign tries_left  = tries_r;
    assign score       = score_r;
    assign state       = state_r;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Bench for guess_round_ctrl: vector table, directed round sequences and a
// randomized run checked every cycle against a round-level reference model.
module tb_guess_round_ctrl;

    localparam int MAXT  = 3;
    localparam int HOLD  = 8;
    localparam int SW    = 2;
    localparam int SMAX  = (1 << SW) - 1;
    localparam int P_IDLE = 0, P_ARM = 1, P_PLAY = 2, P_SHOW = 3;

    logic          clk = 1'b0;
    logic          rst, start, guess_valid;
    logic [5:0]    guess;
    logic          guess_ready, win, lose;
    logic [5:0]    result;
    logic [2:0]    tries_left;
    logic [SW-1:0] score;
    logic [1:0]    state;

    int n_cmp = 0;
    int n_bad = 0;

    guess_round_ctrl #(.MAX_TRIES(MAXT), .HOLD_CYCLES(HOLD), .LFSR_SEED(6'h2D), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .guess(guess), .guess_valid(guess_valid),
        .guess_ready(guess_ready), .result(result), .win(win), .lose(lose),
        .tries_left(tries_left), .score(score), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: the LFSR is a precomputed sequence indexed by cycles since reset.
    logic [5:0] seq [63];
    int         m_age, m_phase, m_tries, m_score, m_shown;
    logic [5:0] m_secret, m_result;
    logic       m_win, m_lose;

    task automatic model_step(input logic r, input logic s, input logic v, input logic [5:0] g);
        if (r) begin
            m_age = 0; m_phase = P_IDLE; m_secret = 6'h00; m_result = 6'h00;
            m_win = 1'b0; m_lose = 1'b0; m_tries = 0; m_score = 0; m_shown = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (s) m_phase = P_ARM;
                P_ARM: begin
                    m_secret = seq[m_age % 63];
                    m_tries = MAXT; m_result = 6'h00; m_win = 1'b0; m_lose = 1'b0;
                    m_phase = P_PLAY;
                end
                P_PLAY: if (v) begin
                    m_result = ~(g ^ m_secret);
                    if (g == m_secret) begin
                        m_win = 1'b1;
                        if (m_score < SMAX) m_score++;
                        m_phase = P_SHOW; m_shown = 0;
                    end else if (m_tries == 1) begin
                        m_lose = 1'b1;
                        m_phase = P_SHOW; m_shown = 0;
                    end
                    if (m_tries > 0) m_tries--;
                end
                default: begin
                    m_shown++;
                    if (m_shown == HOLD) m_phase = s ? P_ARM : P_IDLE;
                end
            endcase
            m_age++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("state", int'(state), m_phase);
        check("guess_ready", int'(guess_ready), (m_phase == P_PLAY) ? 1 : 0);
        check("result", int'(result), int'(m_result));
        check("win", int'(win), int'(m_win));
        check("lose", int'(lose), int'(m_lose));
        check("tries_left", int'(tries_left), m_tries);
        check("score", int'(score), m_score);
    endtask

    // Apply one cycle of inputs at the negedge, then compare after the next negedge.
    task automatic cycle(input logic r, input logic s, input logic v, input logic [5:0] g);
        rst = r; start = s; guess_valid = v; guess = g;
        @(posedge clk);
        model_step(r, s, v, g);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic       r, s, v;
        logic [5:0] g;
        int         st;
        logic [5:0] res;
        logic       w, l;
        int         tr, sc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [5:0] g,
                                input int st, input logic [5:0] res, input logic w, input logic l,
                                input int tr, input int sc);
        vec_t x;
        x.r = r; x.s = s; x.v = v; x.g = g; x.st = st; x.res = res;
        x.w = w; x.l = l; x.tr = tr; x.sc = sc;
        return x;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [16];
        logic [5:0] v;
        rst = 1'b1; start = 1'b0; guess_valid = 1'b0; guess = 6'h00;
        v = 6'h2D;
        for (int i = 0; i < 63; i++) begin
            seq[i] = v;
            v = {v[4:0], v[5] ^ v[4]};
        end

        // Reset, one wrong guess, a win, SHOW with ignored guesses, IDLE, re-arm.
        tbl[0]  = mk(1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 6'h00, 1, 6'h00, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 6'h00, 2, 6'h00, 0, 0, 3, 0);
        tbl[3]  = mk(0, 0, 1, 6'h00, 2, 6'h24, 0, 0, 2, 0);
        tbl[4]  = mk(0, 0, 1, 6'h1B, 3, 6'h3F, 1, 0, 1, 1);
        for (int i = 5; i < 12; i++) tbl[i] = mk(0, 0, 1, 6'h00, 3, 6'h3F, 1, 0, 1, 1);
        tbl[12] = mk(0, 0, 0, 6'h00, 0, 6'h3F, 1, 0, 1, 1);
        tbl[13] = mk(0, 0, 1, 6'h00, 0, 6'h3F, 1, 0, 1, 1);
        tbl[14] = mk(0, 1, 0, 6'h00, 1, 6'h3F, 1, 0, 1, 1);
        tbl[15] = mk(0, 0, 1, 6'h00, 2, 6'h00, 0, 0, 3, 1);
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].g);
            check($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
            check($sformatf("tbl%0d_result", i), int'(result), int'(tbl[i].res));
            check($sformatf("tbl%0d_win", i), int'(win), int'(tbl[i].w));
            check($sformatf("tbl%0d_lose", i), int'(lose), int'(tbl[i].l));
            check($sformatf("tbl%0d_tries", i), int'(tries_left), tbl[i].tr);
            check($sformatf("tbl%0d_score", i), int'(score), tbl[i].sc);
        end

        // Three wrong guesses exhaust the round; SHOW then IDLE with results held.
        cycle(0, 0, 1, m_secret ^ 6'h01);
        check("lose_try1_tries", int'(tries_left), 2);
        cycle(0, 0, 1, m_secret ^ 6'h02);
        check("lose_try2_state", int'(state), 2);
        cycle(0, 0, 1, m_secret ^ 6'h04);
        check("lose_flag", int'(lose), 1);
        check("lose_win", int'(win), 0);
        check("lose_tries", int'(tries_left), 0);
        check("lose_result", int'(result), 6'h3B);
        for (int i = 0; i < HOLD - 1; i++) cycle(0, 0, 0, 6'h00);
        check("lose_show_last", int'(state), 3);
        cycle(0, 0, 0, 6'h00);
        check("lose_to_idle", int'(state), 0);
        cycle(0, 0, 1, 6'h00);
        check("idle_result_held", int'(result), 6'h3B);
        check("idle_lose_held", int'(lose), 1);

        // Reset in the middle of PLAY, then the first round replays with secret 0x1B.
        cycle(0, 1, 0, 6'h00);
        cycle(0, 0, 0, 6'h00);
        cycle(0, 0, 1, m_secret ^ 6'h01);
        cycle(1, 0, 0, 6'h00);
        check("rst_state", int'(state), 0);
        check("rst_result", int'(result), 0);
        check("rst_tries", int'(tries_left), 0);
        check("rst_score", int'(score), 0);
        check("rst_ready", int'(guess_ready), 0);
        cycle(0, 1, 0, 6'h00);
        check("arm_state", int'(state), 1);
        cycle(0, 1, 0, 6'h00);
        check("play_ready", int'(guess_ready), 1);
        cycle(0, 1, 1, 6'h1B);
        check("win1_result", int'(result), 6'h3F);
        check("win1_win", int'(win), 1);
        check("win1_lose", int'(lose), 0);
        check("win1_score", int'(score), 1);
        check("win1_tries", int'(tries_left), 2);
        check("win1_state", int'(state), 3);

        // Back-to-back rounds with start held high; score saturates at 3.
        for (int i = 0; i < HOLD - 1; i++) cycle(0, 1, 0, 6'h00);
        cycle(0, 1, 0, 6'h00);
        check("b2b_arm", int'(state), 1);
        for (int w = 0; w < 3; w++) begin
            cycle(0, 1, 0, 6'h00);
            cycle(0, 1, 1, m_secret);
            check($sformatf("sat_score%0d", w), int'(score), (w + 2 > 3) ? 3 : w + 2);
            check($sformatf("sat_win%0d", w), int'(win), 1);
            for (int i = 0; i < HOLD; i++) cycle(0, 1, 0, 6'h00);
            check($sformatf("sat_b2b%0d", w), int'(state), 1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic r, s, gv;
            logic [5:0] g;
            r  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 3) == 0);
            gv = ($urandom_range(0, 2) == 0);
            g  = ($urandom_range(0, 3) == 0) ? m_secret : 6'($urandom);
            cycle(r, s, gv, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
